mcdt_top: RTL and testbench

Multi-channel data transfer block: three independent 32-bit input channels, each buffered in its own 32-entry FIFO, are merged onto one 32-bit output stream by a fixed-priority arbiter. Every output word carries the ID of its source channel. The block is the top of the channel-merge datapath; upstream producers drive valid/ready channel interfaces, and the downstream consumer samples `mcdt_val_o` with no back-pressure.

---
 rtl/mcdt_pkg.sv | 13 +
 rtl/mcdt_slave_fifo.sv | 59 +++++
 rtl/mcdt_top.sv | 98 +++++++++
 tb/tb_mcdt_top.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcdt_pkg.sv
// rtl/mcdt_pkg.sv - shared constants and types for the channel-merge datapath
package mcdt_pkg;

   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 32;
   localparam int NUM_CH     = 3;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int MARGIN_W   = $clog2(FIFO_DEPTH) + 1;

   typedef logic [1:0]          ch_id_t;
   typedef logic [MARGIN_W-1:0] margin_t;

endpackage

// File: rtl/mcdt_slave_fifo.sv
// rtl/mcdt_slave_fifo.sv - per-channel 32x32 buffer with valid/ready write side and pop request
module mcdt_slave_fifo
   import mcdt_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output margin_t           margin
);

   localparam margin_t DEPTH_M = margin_t'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   margin_t           count;
   logic              push;
   logic              do_pop;

   // ready comes from the pre-edge count, so a full FIFO refuses a push even while popping
   assign wr_ready = (count != DEPTH_M);
   assign empty    = (count == '0);
   assign margin   = DEPTH_M - count;
   assign push     = wr_valid && wr_ready;
   assign do_pop   = pop && !empty;
   assign rd_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mcdt_top.sv
// rtl/mcdt_top.sv - three buffered channels merged onto one tagged stream by fixed priority
module mcdt_top
   import mcdt_pkg::*;
(
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [DATA_W-1:0] ch0_data_i,
   input  logic              ch0_valid_i,
   output logic              ch0_ready_o,
   output margin_t           ch0_margin_o,
   input  logic [DATA_W-1:0] ch1_data_i,
   input  logic              ch1_valid_i,
   output logic              ch1_ready_o,
   output margin_t           ch1_margin_o,
   input  logic [DATA_W-1:0] ch2_data_i,
   input  logic              ch2_valid_i,
   output logic              ch2_ready_o,
   output margin_t           ch2_margin_o,
   output logic [DATA_W-1:0] mcdt_data_o,
   output logic              mcdt_val_o,
   output ch_id_t            mcdt_id_o
);

   logic [DATA_W-1:0] wr_data [NUM_CH];
   logic [NUM_CH-1:0] wr_valid;
   logic [NUM_CH-1:0] wr_ready;
   logic [NUM_CH-1:0] pop;
   logic [DATA_W-1:0] rd_data [NUM_CH];
   logic [NUM_CH-1:0] empty;
   margin_t           margin [NUM_CH];

   logic              grant_val;
   ch_id_t            grant_id;
   logic [DATA_W-1:0] grant_data;

   assign wr_data[0]   = ch0_data_i;
   assign wr_data[1]   = ch1_data_i;
   assign wr_data[2]   = ch2_data_i;
   assign wr_valid     = {ch2_valid_i, ch1_valid_i, ch0_valid_i};
   assign ch0_ready_o  = wr_ready[0];
   assign ch1_ready_o  = wr_ready[1];
   assign ch2_ready_o  = wr_ready[2];
   assign ch0_margin_o = margin[0];
   assign ch1_margin_o = margin[1];
   assign ch2_margin_o = margin[2];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
      mcdt_slave_fifo u_fifo (
         .clk      (clk_i),
         .rstn     (rstn_i),
         .wr_data  (wr_data[g]),
         .wr_valid (wr_valid[g]),
         .wr_ready (wr_ready[g]),
         .pop      (pop[g]),
         .rd_data  (rd_data[g]),
         .empty    (empty[g]),
         .margin   (margin[g])
      );
   end

   // scanning from the lowest priority upward lets ch0 win by overwriting last
   always_comb begin
      grant_val  = 1'b0;
      grant_id   = '0;
      grant_data = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (!empty[i]) begin
            grant_val  = 1'b1;
            grant_id   = ch_id_t'(i);
            grant_data = rd_data[i];
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i] = grant_val && (grant_id == ch_id_t'(i));
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mcdt_val_o  <= 1'b0;
         mcdt_data_o <= '0;
         mcdt_id_o   <= '0;
      end else if (grant_val) begin
         mcdt_val_o  <= 1'b1;
         mcdt_data_o <= grant_data;
         mcdt_id_o   <= grant_id;
      end else begin
         mcdt_val_o  <= 1'b0;
         mcdt_data_o <= '0;
         mcdt_id_o   <= '0;
      end
   end

endmodule

// File: tb/tb_mcdt_top.sv
// tb/tb_mcdt_top.sv - self-checking bench for mcdt_top with per-channel scoreboards
module tb_mcdt_top;
   import mcdt_pkg::*;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   typedef struct {
      int          ch;
      logic [31:0] data;
      ch_id_t      exp_id;
      int          exp_lat;
   } vec_t;

   logic        clk  = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] ch_data [3];
   logic [2:0]  ch_valid;
   logic [2:0]  ch_ready;
   logic [5:0]  ch_margin [3];
   logic [31:0] mcdt_data;
   logic        mcdt_val;
   ch_id_t      mcdt_id;

   exp_t sb [3][$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   mcdt_top dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .ch0_data_i   (ch_data[0]),
      .ch0_valid_i  (ch_valid[0]),
      .ch0_ready_o  (ch_ready[0]),
      .ch0_margin_o (ch_margin[0]),
      .ch1_data_i   (ch_data[1]),
      .ch1_valid_i  (ch_valid[1]),
      .ch1_ready_o  (ch_ready[1]),
      .ch1_margin_o (ch_margin[1]),
      .ch2_data_i   (ch_data[2]),
      .ch2_valid_i  (ch_valid[2]),
      .ch2_ready_o  (ch_ready[2]),
      .ch2_margin_o (ch_margin[2]),
      .mcdt_data_o  (mcdt_data),
      .mcdt_val_o   (mcdt_val),
      .mcdt_id_o    (mcdt_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // output monitor: every produced word must match the head of its channel's queue
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         check("val_in_reset", {63'd0, mcdt_val}, 64'd0);
      end else if (!mcdt_val) begin
         check("idle_outputs_zero", {30'd0, mcdt_id, mcdt_data}, 64'd0);
      end else if (mcdt_id == 2'd3) begin
         n_checks++;
         n_fail++;
         $display("FAIL out_id_range: got 3 required 0..2 (cycle %0d)", cyc);
      end else if (sb[mcdt_id].size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_out: got data 0x%0h id %0d required no output (cycle %0d)",
                  mcdt_data, mcdt_id, cyc);
      end else begin
         e = sb[mcdt_id].pop_front();
         check("out_data", {32'd0, mcdt_data}, {32'd0, e.data});
         if (e.cyc >= 0) check("out_cycle", 64'(cyc), 64'(e.cyc));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ch_valid = '0;
      for (int c = 0; c < 3; c++) ch_data[c] = '0;
   endtask

   task automatic present(int ch, logic [31:0] d, ch_id_t exp_id, int lat);
      ch_data[ch]  = d;
      ch_valid[ch] = 1'b1;
      sb[exp_id].push_back('{data: d, cyc: (lat < 0) ? -1 : cyc + lat});
   endtask

   task automatic drain(string name, int budget);
      int t = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && t < budget) begin
         step();
         t++;
      end
      check(name, 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'd0);
      repeat (2) step();
   endtask

   task automatic check_ports(string name);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("%s_margin%0d", name, c), {58'd0, ch_margin[c]}, 64'd32);
         check($sformatf("%s_ready%0d", name, c), {63'd0, ch_ready[c]}, 64'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [30];
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 10; i++) begin
            vecs[c*10+i] = '{ch: c, data: 32'h00C0_0000 + (32'(c) << 16) + 32'(i),
                             exp_id: ch_id_t'(c), exp_lat: 2};
         end
      end

      // reset state
      idle_inputs();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_val", {63'd0, mcdt_val}, 64'd0);
      check("reset_data_id", {30'd0, mcdt_id, mcdt_data}, 64'd0);
      check_ports("reset");
      step();
      rstn = 1'b1;
      repeat (5) step();
      check_ports("post_reset");

      // single-beat writes, one every two cycles, per channel
      for (int v = 0; v < 30; v++) begin
         idle_inputs();
         present(vecs[v].ch, vecs[v].data, vecs[v].exp_id, vecs[v].exp_lat);
         step();
         idle_inputs();
         check("margin_after_write", {58'd0, ch_margin[vecs[v].ch]}, 64'd31);
         step();
         check("margin_after_pop", {58'd0, ch_margin[vecs[v].ch]}, 64'd32);
      end
      drain("drain_single", 20);
      check_ports("after_single");

      // simultaneous writes on all channels: emitted on consecutive cycles by priority
      idle_inputs();
      present(0, 32'h0000_000A, 2'd0, 2);
      present(1, 32'h0000_000B, 2'd1, 3);
      present(2, 32'h0000_000C, 2'd2, 4);
      step();
      idle_inputs();
      drain("drain_simul", 20);

      // ch2 starved while ch0 keeps receiving a word every cycle
      for (int i = 0; i < 6; i++) begin
         idle_inputs();
         if (i == 0) present(2, 32'h0000_2222, 2'd2, 8);
         present(0, 32'h0000_1000 + 32'(i), 2'd0, 2);
         step();
      end
      idle_inputs();
      drain("drain_starve", 30);

      // fill ch1 to full behind a continuous ch0 stream; the 33rd ch1 write is dropped
      for (int i = 0; i < 40; i++) begin
         idle_inputs();
         present(0, 32'h00F0_0000 + 32'(i), 2'd0, -1);
         if (i < 32) begin
            present(1, 32'h00F1_0000 + 32'(i), 2'd1, -1);
         end else if (i == 32) begin
            check("full_margin", {58'd0, ch_margin[1]}, 64'd0);
            check("full_ready", {63'd0, ch_ready[1]}, 64'd0);
            ch_data[1]  = 32'hDEAD_0033;
            ch_valid[1] = 1'b1;
         end else if (i == 33) begin
            check("full_margin_after_drop", {58'd0, ch_margin[1]}, 64'd0);
         end
         step();
      end
      idle_inputs();
      drain("drain_full", 200);
      check_ports("after_full");

      // reset mid-stream discards everything buffered
      for (int i = 0; i < 6; i++) begin
         idle_inputs();
         present(0, 32'h00E0_0000 + 32'(i), 2'd0, -1);
         present(1, 32'h00E1_0000 + 32'(i), 2'd1, -1);
         step();
      end
      #2;
      rstn = 1'b0;
      for (int c = 0; c < 3; c++) sb[c].delete();
      idle_inputs();
      ch_data[0]  = 32'hBAD0_0000;
      ch_valid[0] = 1'b1;
      #1;
      check("midreset_val", {63'd0, mcdt_val}, 64'd0);
      check("midreset_data_id", {30'd0, mcdt_id, mcdt_data}, 64'd0);
      check_ports("midreset");
      repeat (3) step();
      idle_inputs();
      rstn = 1'b1;
      repeat (8) step();
      check_ports("after_midreset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
